// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount greedily (largest coin first) over a
// per-coin fire/ack handshake to three hoppers, skipping empty ones and aborting on ack timeout.
module change_dispenser #(
  parameter int AW      = 6,
  parameter int V2      = 4,
  parameter int V1      = 2,
  parameter int V0      = 1,
  parameter int TIMEOUT = 15,
  parameter int GAP     = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic [AW-1:0] amount,
  input  logic [2:0]    empty,
  input  logic          coin_ack,
  output logic [2:0]    coin_fire,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] remaining
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [AW-1:0] C2 = AW'(V2);
  localparam logic [AW-1:0] C1 = AW'(V1);
  localparam logic [AW-1:0] C0 = AW'(V0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    FIRE   = 3'd2,
    GAPW   = 3'd3,
    DONE   = 3'd4,
    FAULT  = 3'd5
  } state_t;

  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [GW-1:0] gap_r;
  logic [AW-1:0] coin_val_r;
  logic [2:0]    pick_s;
  logic [AW-1:0] pick_val_s;

  // Largest non-empty coin that still fits into the amount owed.
  always_comb begin
    pick_s     = 3'b000;
    pick_val_s = '0;
    if (!empty[2] && (remaining >= C2)) begin
      pick_s     = 3'b100;
      pick_val_s = C2;
    end else if (!empty[1] && (remaining >= C1)) begin
      pick_s     = 3'b010;
      pick_val_s = C1;
    end else if (!empty[0] && (remaining >= C0)) begin
      pick_s     = 3'b001;
      pick_val_s = C0;
    end else begin
      pick_s     = 3'b000;
      pick_val_s = '0;
    end
  end

  // Payout sequencer; busy drops as DONE/FAULT is entered, the pulse follows one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      timer_r    <= '0;
      gap_r      <= '0;
      coin_val_r <= '0;
      coin_fire  <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      remaining  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req) begin
            remaining <= amount;
            busy      <= 1'b1;
            state_r   <= SELECT;
          end else begin
            state_r <= IDLE;
          end
        end
        SELECT: begin
          timer_r <= '0;
          if (remaining == '0) begin
            busy    <= 1'b0;
            state_r <= DONE;
          end else if (pick_s != 3'b000) begin
            coin_fire  <= pick_s;
            coin_val_r <= pick_val_s;
            state_r    <= FIRE;
          end else begin
            busy    <= 1'b0;
            state_r <= FAULT;
          end
        end
        FIRE: begin
          // An ack on the final timeout cycle still counts as a paid coin.
          if (coin_ack) begin
            remaining <= remaining - coin_val_r;
            coin_fire <= 3'b000;
            gap_r     <= '0;
            state_r   <= (GAP == 0) ? SELECT : GAPW;
          end else if (timer_r == TW'(TIMEOUT - 1)) begin
            coin_fire <= 3'b000;
            busy      <= 1'b0;
            state_r   <= FAULT;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        GAPW: begin
          if (gap_r == GW'(GAP - 1)) begin
            state_r <= SELECT;
          end else begin
            gap_r <= gap_r + GW'(1);
          end
        end
        DONE: begin
          done    <= 1'b1;
          state_r <= IDLE;
        end
        FAULT: begin
          err     <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          coin_fire <= 3'b000;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
